// File: rtl/res_station_multi.sv
// Multi-entry reservation station: CDB wakeup, oldest-ready select, valid/ready issue.
// Optional perf counters (issued / full stall / ready blocked) enabled by RS_PERF_CNT_EN.
module res_station_multi #(
  parameter int DEPTH     = 8,
  parameter int NUM_CDB   = 2,
  parameter int PREG_W    = 6,
  parameter int ROB_W     = 4,
  parameter int PAYLOAD_W = 96
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic                      disp_ps1_valid,
  input  logic [PREG_W-1:0]         disp_ps1,
  input  logic                      disp_ps2_valid,
  input  logic [PREG_W-1:0]         disp_ps2,
  input  logic [PREG_W-1:0]         disp_pd,
  input  logic [ROB_W-1:0]          disp_rob,
  input  logic [PAYLOAD_W-1:0]      disp_payload,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*PREG_W-1:0] cdb_pd,
  output logic                      iss_valid,
  input  logic                      iss_ready,
  output logic [PREG_W-1:0]         iss_ps1,
  output logic [PREG_W-1:0]         iss_ps2,
  output logic [PREG_W-1:0]         iss_pd,
  output logic [ROB_W-1:0]          iss_rob,
  output logic [PAYLOAD_W-1:0]      iss_payload,
`ifdef RS_PERF_CNT_EN
  output logic [31:0]               perf_issued,
  output logic [31:0]               perf_full_stall,
  output logic [31:0]               perf_ready_blocked,
`endif
  output logic [$clog2(DEPTH):0]    count
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] ONE  = (IDX_W+1)'(1);

  logic [DEPTH-1:0]     valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  // age_q[i][j] set means entry i was allocated before entry j
  logic [DEPTH-1:0]     age_q [DEPTH];
  logic [DEPTH-1:0]     age_d [DEPTH];
  logic [PREG_W-1:0]    ps1_q [DEPTH];
  logic [PREG_W-1:0]    ps2_q [DEPTH];
  logic [PREG_W-1:0]    pd_q  [DEPTH];
  logic [ROB_W-1:0]     rob_q [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  logic [IDX_W:0]       count_q, count_d;
  logic [DEPTH-1:0]     ready, grant;
  logic [IDX_W-1:0]     free_idx;
  logic                 accept, pop;

  function automatic logic cdb_hit(input logic [PREG_W-1:0] tag,
                                   input logic [NUM_CDB-1:0] vld,
                                   input logic [NUM_CDB*PREG_W-1:0] tags);
    cdb_hit = 1'b0;
    for (int k = 0; k < NUM_CDB; k++)
      if (vld[k] && tags[k*PREG_W +: PREG_W] == tag) cdb_hit = 1'b1;
  endfunction

  assign disp_ready = (count_q < FULL);
  assign accept     = disp_valid && disp_ready && !flush;
  assign iss_valid  = |ready;
  assign pop        = iss_valid && iss_ready;
  assign count      = count_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
    logic [DEPTH-1:0] older;
    for (genvar gj = 0; gj < DEPTH; gj++) begin : g_col
      assign older[gj] = age_q[gj][gi];
    end
    assign ready[gi] = valid_q[gi] & rdy1_q[gi] & rdy2_q[gi];
    assign grant[gi] = ready[gi] & ~|(ready & older);
  end

  always_comb begin
    iss_ps1 = '0; iss_ps2 = '0; iss_pd = '0; iss_rob = '0; iss_payload = '0;
    for (int i = 0; i < DEPTH; i++) begin
      iss_ps1     = iss_ps1     | ({PREG_W{grant[i]}}    & ps1_q[i]);
      iss_ps2     = iss_ps2     | ({PREG_W{grant[i]}}    & ps2_q[i]);
      iss_pd      = iss_pd      | ({PREG_W{grant[i]}}    & pd_q[i]);
      iss_rob     = iss_rob     | ({ROB_W{grant[i]}}     & rob_q[i]);
      iss_payload = iss_payload | ({PAYLOAD_W{grant[i]}} & payload_q[i]);
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!valid_q[i]) free_idx = IDX_W'(i);
  end

  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    age_d   = age_q;
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_hit(ps1_q[i], cdb_valid, cdb_pd)) rdy1_d[i] = 1'b1;
      if (cdb_hit(ps2_q[i], cdb_valid, cdb_pd)) rdy2_d[i] = 1'b1;
    end
    if (pop) valid_d = valid_d & ~grant;
    if (accept) begin
      valid_d[free_idx] = 1'b1;
      rdy1_d[free_idx]  = (disp_ps1 == '0) || disp_ps1_valid || cdb_hit(disp_ps1, cdb_valid, cdb_pd);
      rdy2_d[free_idx]  = (disp_ps2 == '0) || disp_ps2_valid || cdb_hit(disp_ps2, cdb_valid, cdb_pd);
      age_d[free_idx]   = '0;
      for (int j = 0; j < DEPTH; j++)
        if (j != int'(free_idx)) age_d[j][free_idx] = 1'b1;
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
    if (flush) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      count_q <= count_d;
      age_q   <= age_d;
    end
  end

  // Payload storage needs no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (accept) begin
      ps1_q[free_idx]     <= disp_ps1;
      ps2_q[free_idx]     <= disp_ps2;
      pd_q[free_idx]      <= disp_pd;
      rob_q[free_idx]     <= disp_rob;
      payload_q[free_idx] <= disp_payload;
    end
  end

`ifdef RS_PERF_CNT_EN
  logic [31:0] perf_issued_q, perf_full_stall_q, perf_ready_blocked_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued_q        <= '0;
      perf_full_stall_q    <= '0;
      perf_ready_blocked_q <= '0;
    end else begin
      if (pop && perf_issued_q != 32'hFFFF_FFFF) perf_issued_q <= perf_issued_q + 32'd1;
      if (disp_valid && !disp_ready && perf_full_stall_q != 32'hFFFF_FFFF)
        perf_full_stall_q <= perf_full_stall_q + 32'd1;
      if (iss_valid && !iss_ready && perf_ready_blocked_q != 32'hFFFF_FFFF)
        perf_ready_blocked_q <= perf_ready_blocked_q + 32'd1;
    end
  end
  assign perf_issued        = perf_issued_q;
  assign perf_full_stall    = perf_full_stall_q;
  assign perf_ready_blocked = perf_ready_blocked_q;
`endif
endmodule

// File: tb/tb_res_station_multi.sv
// Directed self-checking bench for res_station_multi (default parameters).
module tb_res_station_multi;
  localparam int PREG_W = 6, ROB_W = 4, PAYLOAD_W = 96, NUM_CDB = 2;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic disp_valid = 1'b0, disp_ready;
  logic disp_ps1_valid = 1'b0, disp_ps2_valid = 1'b0;
  logic [PREG_W-1:0] disp_ps1 = '0, disp_ps2 = '0, disp_pd = '0;
  logic [ROB_W-1:0] disp_rob = '0;
  logic [PAYLOAD_W-1:0] disp_payload = '0;
  logic [NUM_CDB-1:0] cdb_valid = '0;
  logic [NUM_CDB*PREG_W-1:0] cdb_pd = '0;
  logic iss_valid, iss_ready = 1'b0;
  logic [PREG_W-1:0] iss_ps1, iss_ps2, iss_pd;
  logic [ROB_W-1:0] iss_rob;
  logic [PAYLOAD_W-1:0] iss_payload;
  logic [3:0] count;
`ifdef RS_PERF_CNT_EN
  logic [31:0] perf_issued, perf_full_stall, perf_ready_blocked;
`endif
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  res_station_multi dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_ps1_valid(disp_ps1_valid), .disp_ps1(disp_ps1),
    .disp_ps2_valid(disp_ps2_valid), .disp_ps2(disp_ps2),
    .disp_pd(disp_pd), .disp_rob(disp_rob), .disp_payload(disp_payload),
    .cdb_valid(cdb_valid), .cdb_pd(cdb_pd),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_ps1(iss_ps1), .iss_ps2(iss_ps2), .iss_pd(iss_pd),
    .iss_rob(iss_rob), .iss_payload(iss_payload),
`ifdef RS_PERF_CNT_EN
    .perf_issued(perf_issued), .perf_full_stall(perf_full_stall),
    .perf_ready_blocked(perf_ready_blocked),
`endif
    .count(count)
  );

  // Advance one clock, then let outputs settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic disp(input logic [PREG_W-1:0] ps1, input logic v1,
                      input logic [PREG_W-1:0] ps2, input logic v2,
                      input logic [PREG_W-1:0] pd);
    disp_valid = 1'b1;
    disp_ps1 = ps1; disp_ps1_valid = v1;
    disp_ps2 = ps2; disp_ps2_valid = v2;
    disp_pd = pd;
    disp_rob = pd[ROB_W-1:0];
    disp_payload = {32'hA5A5_0000 | 32'(pd), 32'hDEAD_BEEF, 32'(pd) * 32'd3};
  endtask

  task automatic no_disp();
    disp_valid = 1'b0;
  endtask

  task automatic set_cdb(input logic [1:0] v, input logic [PREG_W-1:0] t0, input logic [PREG_W-1:0] t1);
    cdb_valid = v;
    cdb_pd = {t1, t0};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (disp_ready !== 1'b1) begin failures++; $display("FAIL reset_disp_ready got=%b exp=1", disp_ready); end
    checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL reset_iss_valid got=%b exp=0", iss_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    $display("test_reset done");
  endtask

  task automatic test_in_order();
    logic [PAYLOAD_W-1:0] exp_pl;
    iss_ready = 1'b1;
    disp(6'd7, 1'b1, 6'd0, 1'b0, 6'd2); settle();
    checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL inord_empty iss_valid got=%b exp=0", iss_valid); end
    step();
    disp(6'd7, 1'b1, 6'd0, 1'b0, 6'd3); settle();
    exp_pl = {32'hA5A5_0002, 32'hDEAD_BEEF, 32'd6};
    checks++; if (iss_valid !== 1'b1 || iss_pd !== 6'd2) begin failures++; $display("FAIL inord_pd2 got v=%b pd=%0d exp v=1 pd=2", iss_valid, iss_pd); end
    checks++; if (iss_payload !== exp_pl || iss_rob !== 4'd2 || iss_ps1 !== 6'd7) begin failures++; $display("FAIL inord_fields got pl=%h rob=%0d ps1=%0d exp pl=%h rob=2 ps1=7", iss_payload, iss_rob, iss_ps1, exp_pl); end
    step();
    disp(6'd7, 1'b1, 6'd0, 1'b0, 6'd4); settle();
    checks++; if (iss_valid !== 1'b1 || iss_pd !== 6'd3) begin failures++; $display("FAIL inord_pd3 got v=%b pd=%0d exp v=1 pd=3", iss_valid, iss_pd); end
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL inord_count_bb got=%0d exp=1", count); end
    step();
    no_disp(); settle();
    checks++; if (iss_valid !== 1'b1 || iss_pd !== 6'd4) begin failures++; $display("FAIL inord_pd4 got v=%b pd=%0d exp v=1 pd=4", iss_valid, iss_pd); end
    step();
    checks++; if (count !== 4'd0 || iss_valid !== 1'b0) begin failures++; $display("FAIL inord_drain got count=%0d v=%b exp count=0 v=0", count, iss_valid); end
    $display("test_in_order done");
  endtask

  task automatic test_wakeup();
    iss_ready = 1'b1;
    disp(6'd5, 1'b0, 6'd0, 1'b0, 6'd10); step();
    disp(6'd0, 1'b0, 6'd0, 1'b0, 6'd11); settle();
    checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL wake_a_not_ready got v=%b exp=0", iss_valid); end
    step();
    no_disp(); settle();
    checks++; if (iss_valid !== 1'b1 || iss_pd !== 6'd11) begin failures++; $display("FAIL wake_b_first got v=%b pd=%0d exp v=1 pd=11", iss_valid, iss_pd); end
    step();
    set_cdb(2'b10, 6'd63, 6'd5); settle();
    checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL wake_same_cycle got v=%b exp=0", iss_valid); end
    step();
    set_cdb(2'b00, 6'd0, 6'd0); settle();
    checks++; if (iss_valid !== 1'b1 || iss_pd !== 6'd10 || iss_ps1 !== 6'd5) begin failures++; $display("FAIL wake_a_issue got v=%b pd=%0d ps1=%0d exp v=1 pd=10 ps1=5", iss_valid, iss_pd, iss_ps1); end
    step();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL wake_count got=%0d exp=0", count); end
    $display("test_wakeup done");
  endtask

  task automatic test_bypass();
    iss_ready = 1'b1;
    disp(6'd0, 1'b0, 6'd9, 1'b0, 6'd12);
    set_cdb(2'b01, 6'd9, 6'd0); step();
    no_disp(); set_cdb(2'b00, 6'd0, 6'd0); settle();
    checks++; if (iss_valid !== 1'b1 || iss_pd !== 6'd12 || iss_ps2 !== 6'd9) begin failures++; $display("FAIL bypass_issue got v=%b pd=%0d ps2=%0d exp v=1 pd=12 ps2=9", iss_valid, iss_pd, iss_ps2); end
    step();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL bypass_count got=%0d exp=0", count); end
    $display("test_bypass done");
  endtask

  task automatic test_full();
    iss_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      disp(6'(20 + i), 1'b0, 6'd0, 1'b0, 6'(30 + i)); settle();
      checks++; if (disp_ready !== 1'b1) begin failures++; $display("FAIL full_fill_ready[%0d] got=%b exp=1", i, disp_ready); end
      step();
    end
    no_disp(); settle();
    checks++; if (count !== 4'd8 || disp_ready !== 1'b0) begin failures++; $display("FAIL full_state got count=%0d rdy=%b exp count=8 rdy=0", count, disp_ready); end
    disp(6'd0, 1'b0, 6'd0, 1'b0, 6'd50); step();
    no_disp(); settle();
    checks++; if (count !== 4'd8 || iss_valid !== 1'b0) begin failures++; $display("FAIL full_extra_ignored got count=%0d v=%b exp count=8 v=0", count, iss_valid); end
    set_cdb(2'b01, 6'd23, 6'd0); step();
    set_cdb(2'b00, 6'd0, 6'd0); iss_ready = 1'b1; settle();
    checks++; if (iss_valid !== 1'b1 || iss_pd !== 6'd33) begin failures++; $display("FAIL full_wake_one got v=%b pd=%0d exp v=1 pd=33", iss_valid, iss_pd); end
    step();
    iss_ready = 1'b0; settle();
    checks++; if (disp_ready !== 1'b1 || count !== 4'd7) begin failures++; $display("FAIL full_after_pop got rdy=%b count=%0d exp rdy=1 count=7", disp_ready, count); end
    flush = 1'b1; step(); flush = 1'b0; settle();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL full_cleanup got count=%0d exp=0", count); end
    $display("test_full done");
  endtask

  task automatic test_age_wrap();
    iss_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      disp(6'(40 + i), 1'b0, 6'd0, 1'b0, 6'(60 + i)); step();
    end
    no_disp(); set_cdb(2'b01, 6'd41, 6'd0); step();
    set_cdb(2'b00, 6'd0, 6'd0); iss_ready = 1'b1; settle();
    checks++; if (iss_valid !== 1'b1 || iss_pd !== 6'd61) begin failures++; $display("FAIL age_pop_idx1 got v=%b pd=%0d exp v=1 pd=61", iss_valid, iss_pd); end
    step();
    iss_ready = 1'b0;
    disp(6'd0, 1'b0, 6'd0, 1'b0, 6'd7); set_cdb(2'b10, 6'd0, 6'd45); step();
    no_disp(); set_cdb(2'b00, 6'd0, 6'd0);
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if (iss_valid !== 1'b1 || iss_pd !== 6'd65) begin failures++; $display("FAIL age_hold[%0d] got v=%b pd=%0d exp v=1 pd=65", c, iss_valid, iss_pd); end
      step();
    end
    iss_ready = 1'b1; settle();
    checks++; if (iss_pd !== 6'd65) begin failures++; $display("FAIL age_oldest_pop got pd=%0d exp=65", iss_pd); end
    step();
    checks++; if (iss_valid !== 1'b1 || iss_pd !== 6'd7) begin failures++; $display("FAIL age_younger_next got v=%b pd=%0d exp v=1 pd=7", iss_valid, iss_pd); end
    step();
    iss_ready = 1'b0; settle();
    checks++; if (count !== 4'd4 || iss_valid !== 1'b0) begin failures++; $display("FAIL age_remaining got count=%0d v=%b exp count=4 v=0", count, iss_valid); end
    $display("test_age_wrap done");
  endtask

  task automatic test_flush();
    iss_ready = 1'b0;
    set_cdb(2'b11, 6'd40, 6'd42); step();
    set_cdb(2'b00, 6'd0, 6'd0); settle();
    checks++; if (iss_valid !== 1'b1 || count !== 4'd4) begin failures++; $display("FAIL flush_pre got v=%b count=%0d exp v=1 count=4", iss_valid, count); end
    flush = 1'b1; disp(6'd0, 1'b0, 6'd0, 1'b0, 6'd55); step();
    flush = 1'b0; no_disp(); settle();
    checks++; if (count !== 4'd0 || iss_valid !== 1'b0) begin failures++; $display("FAIL flush_clear got count=%0d v=%b exp count=0 v=0", count, iss_valid); end
    step();
    checks++; if (count !== 4'd0 || iss_valid !== 1'b0 || disp_ready !== 1'b1) begin failures++; $display("FAIL flush_no_store got count=%0d v=%b rdy=%b exp 0 0 1", count, iss_valid, disp_ready); end
    $display("test_flush done");
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_wakeup();
    test_bypass();
    test_full();
    test_age_wrap();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
